// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: command encodings, FSM state type
// and the helper that turns a 4-bit blink count into the 5-bit counter load.
package led_seq_pkg;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_ON     = 2'b01;
    localparam logic [1:0] MODE_TOGGLE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    localparam int BLINK_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ON_PH  = 2'b01,
        OFF_PH = 2'b10
    } state_t;

    // A count of zero stands for sixteen blinks, so the counter needs one
    // more bit than the command field.
    function automatic logic [BLINK_CNT_W-1:0] blinkLoad(input logic [3:0] count);
        logic [BLINK_CNT_W-1:0] result;
        if (count == 4'd0) begin
            result = 5'd16;
        end else begin
            result = {1'b0, count};
        end
        return result;
    endfunction

endpackage

// File: rtl/led_seq_phase_timer.sv
// Half-period timer: counts enabled cycles from 0 to HALF_PERIOD-1 and wraps,
// flagging the last cycle of each phase on expire.
module phase_timer
    import led_seq_pkg::*;
#(
    parameter int HALF_PERIOD = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [TW-1:0] LAST = TW'(HALF_PERIOD - 1);

    logic [TW-1:0] r_count;

    // Phase counter; clear wins over enable, and the wrap at LAST keeps the
    // count inside its range so it never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + TW'(1);
            end
        end
    end

    assign expire = (r_count == LAST);

endmodule

// File: rtl/led_seq.sv
// LED sequencer: static OFF/ON/TOGGLE level plus a BLINK sequence of N
// on/off cycles, each phase HALF_PERIOD clocks long, with abort and a
// completion pulse.
module led_seq
    import led_seq_pkg::*;
#(
    parameter int HALF_PERIOD = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_count,
    input  logic       abort,
    output logic       led,
    output logic       busy,
    output logic       done
);

    state_t                 r_state;
    logic                   r_lvl;
    logic                   r_led;
    logic                   r_done;
    logic [BLINK_CNT_W-1:0] r_blinkCnt;

    state_t                 w_nextState;
    logic                   w_nextLvl;
    logic                   w_nextLed;
    logic                   w_nextDone;
    logic [BLINK_CNT_W-1:0] w_nextBlinkCnt;
    logic                   w_timerClr;
    logic                   w_timerEn;
    logic                   w_timerExpire;
    logic                   w_accept;
    logic                   w_lastBlink;

    // Commands are only taken in IDLE; gating with rst_n keeps ready low
    // for the whole time reset is held, even though the state already reads IDLE.
    assign cmd_ready   = (r_state == IDLE) && rst_n;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_lastBlink = (r_blinkCnt <= 5'd1);

    phase_timer #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_phaseTimer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_timerClr),
        .en    (w_timerEn),
        .expire(w_timerExpire)
    );

    // Next-state logic: static commands stay in IDLE, BLINK walks ON_PH/OFF_PH
    // until the counter runs out, abort drops straight back to IDLE.
    always_comb begin
        w_nextState    = r_state;
        w_nextLvl      = r_lvl;
        w_nextBlinkCnt = r_blinkCnt;
        w_nextDone     = 1'b0;
        w_timerClr     = 1'b0;
        w_timerEn      = 1'b0;

        case (r_state)
            IDLE: begin
                w_timerClr = 1'b1;
                if (w_accept) begin
                    case (cmd_mode)
                        MODE_OFF:    w_nextLvl = 1'b0;
                        MODE_ON:     w_nextLvl = 1'b1;
                        MODE_TOGGLE: w_nextLvl = ~r_lvl;
                        default: begin
                            w_nextBlinkCnt = blinkLoad(cmd_count);
                            w_nextState    = ON_PH;
                        end
                    endcase
                end
            end

            ON_PH: begin
                if (abort) begin
                    w_nextState    = IDLE;
                    w_timerClr     = 1'b1;
                    w_nextBlinkCnt = '0;
                end else begin
                    w_timerEn = 1'b1;
                    if (w_timerExpire) begin
                        w_nextState = OFF_PH;
                    end
                end
            end

            OFF_PH: begin
                if (abort) begin
                    w_nextState    = IDLE;
                    w_timerClr     = 1'b1;
                    w_nextBlinkCnt = '0;
                end else begin
                    w_timerEn = 1'b1;
                    if (w_timerExpire) begin
                        if (r_blinkCnt != '0) begin
                            w_nextBlinkCnt = r_blinkCnt - 5'd1;
                        end
                        if (w_lastBlink) begin
                            w_nextState = IDLE;
                            w_nextDone  = 1'b1;
                        end else begin
                            w_nextState = ON_PH;
                        end
                    end
                end
            end

            default: begin
                w_nextState    = IDLE;
                w_timerClr     = 1'b1;
                w_nextBlinkCnt = '0;
            end
        endcase
    end

    // The LED register follows the state being entered so it changes in the
    // same cycle the state does; outside a blink it shows the static level.
    always_comb begin
        case (w_nextState)
            ON_PH:   w_nextLed = 1'b1;
            OFF_PH:  w_nextLed = 1'b0;
            default: w_nextLed = w_nextLvl;
        endcase
    end

    // State, level, counter and output registers, all cleared by reset so a
    // sequence cut short by reset leaves no done pulse behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lvl      <= 1'b0;
            r_led      <= 1'b0;
            r_done     <= 1'b0;
            r_blinkCnt <= '0;
        end else begin
            r_state    <= w_nextState;
            r_lvl      <= w_nextLvl;
            r_led      <= w_nextLed;
            r_done     <= w_nextDone;
            r_blinkCnt <= w_nextBlinkCnt;
        end
    end

    assign led  = r_led;
    assign done = r_done;
    assign busy = (r_state == ON_PH) || (r_state == OFF_PH);

endmodule

// File: doc/led_seq.md
LED_SEQ -- requirements
Module: led_seq

Interface
REQ-001 The block SHALL have parameter HALF_PERIOD, default 50000000, meaning clock cycles per blink half-phase (minimum 2).
REQ-002 The block SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1, meaning a command is presented.
REQ-005 The block SHALL have port cmd_ready, output, 1, meaning the block can accept a command.
REQ-006 The block SHALL have port cmd_mode, input, 2, meaning command: 00 OFF, 01 ON, 10 TOGGLE, 11 BLINK.
REQ-007 The block SHALL have port cmd_count, input, 4, meaning the number of blinks for BLINK, where 0 encodes 16.
REQ-008 The block SHALL have port abort, input, 1, meaning terminate an active blink sequence.
REQ-009 The block SHALL have port led, output, 1, meaning the registered LED drive.
REQ-010 The block SHALL have port busy, output, 1, meaning a blink sequence is in progress.
REQ-011 The block SHALL have port done, output, 1, meaning a one-cycle pulse on normal blink completion.

Function
REQ-012 A command SHALL be accepted on a rising clk edge where cmd_valid and cmd_ready are both 1; cmd_mode and cmd_count are sampled on that edge only.
REQ-013 cmd_ready SHALL equal (state == IDLE) and SHALL be 0 while rst_n is low.
REQ-014 The block SHALL hold an internal static level, lvl (reset 0), which only OFF, ON, and TOGGLE modify.
REQ-015 OFF, ON, and TOGGLE SHALL set lvl to 0, 1, and ~lvl respectively, with led showing the new lvl in the cycle after acceptance; the state SHALL remain IDLE and busy SHALL remain 0.
REQ-016 Acceptance of BLINK SHALL load the blink counter with cmd_count (16 if cmd_count is 0), set the phase timer to 0, and enter ON_PH.
REQ-017 In ON_PH, led SHALL be 1 for exactly HALF_PERIOD cycles, after which the state SHALL go to OFF_PH.
REQ-018 In OFF_PH, led SHALL be 0 for exactly HALF_PERIOD cycles, after which the blink counter SHALL decrement.
REQ-019 At the end of OFF_PH, the block SHALL return to ON_PH if blinks remain, otherwise go to IDLE.
REQ-020 On a normal return to IDLE, led SHALL equal lvl and done SHALL be 1 for that single cycle, in which cmd_ready is also 1.
REQ-021 A BLINK of N blinks SHALL occupy exactly 2*N*HALF_PERIOD cycles with busy=1, from the cycle after acceptance.
REQ-022 busy SHALL be 1 exactly when the state is ON_PH or OFF_PH.
REQ-023 abort=1 sampled in ON_PH or OFF_PH SHALL force IDLE on that edge, with led=lvl in the next cycle and done=0.
REQ-024 abort SHALL be ignored in IDLE, so that a simultaneous abort and command acceptance in IDLE accepts the command.
REQ-025 cmd_valid during a blink SHALL have no effect; no command is queued.
REQ-026 The phase timer SHALL be $clog2(HALF_PERIOD) bits wide and SHALL wrap to 0 at HALF_PERIOD-1 with no overflow.
REQ-027 The blink counter SHALL be 5 bits wide and SHALL never underflow.
REQ-028 The states SHALL be exactly IDLE, ON_PH, and OFF_PH; unreachable encodings SHALL return to IDLE.

Reset
REQ-029 While rst_n is low, the block SHALL asynchronously force: state=IDLE, led=0, lvl=0, busy=0, done=0, timer=0, blink counter=0, cmd_ready=0.
REQ-030 Reset asserted mid-blink SHALL discard the sequence without a done pulse.
REQ-031 The first command SHALL be acceptable on the first rising edge after rst_n deasserts.

Structure
REQ-032 The shared package led_seq_pkg SHALL hold the mode encodings (MODE_OFF, MODE_ON, MODE_TOGGLE, MODE_BLINK) and the state enum type.
REQ-033 The half-period timer SHALL be a sub-module phase_timer (parameter HALF_PERIOD; inputs clk, rst_n, clr, en; output expire, asserted in the last cycle of a phase).
REQ-034 No other sub-modules SHALL be used; the state machine and counters SHALL live in led_seq.

Verification (HALF_PERIOD=4)
REQ-035 The bench SHALL check reset and ON: release rst_n, then send ON -> led=1 the next cycle, busy=0, and cmd_ready stays 1.
REQ-036 The bench SHALL check TOGGLE: send TOGGLE three times from lvl=0 -> led sequence 1, 0, 1, each one cycle after acceptance.
REQ-037 The bench SHALL check BLINK with count 2: BLINK count=2 from lvl=0 -> led pattern 1111 0000 1111 0000, busy=1 for 16 cycles, done one cycle with led=0, and cmd_ready=1.
REQ-038 The bench SHALL check BLINK with count 0 and lvl=1: BLINK count=0 with lvl=1 -> 16 blinks (128 busy cycles), then led=1 and a done pulse.
REQ-039 The bench SHALL check abort: BLINK count=3, abort at cycle 6 -> IDLE next edge, led=lvl, done never 1, and a new ON accepted in the following cycle.
REQ-040 The bench SHALL check reset mid-blink: assert rst_n low at cycle 5 of a BLINK -> led=0 and busy=0 immediately (asynchronously), with no done pulse.
